// File: rtl/oc8051_prog_rom.sv
// oc8051 program ROM: byte-wide synchronous-read array, FETCH_BYTES-wide fetch FSM, serial load port.
// Optional one-entry last-fetch cache enabled by defining OC8051_ROM_CACHE_EN.
module oc8051_prog_rom #(
    parameter int unsigned INT_ROM_WID = 7,
    parameter int unsigned FETCH_BYTES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic [15:0]              addr,
    output logic                     ack,
    output logic [8*FETCH_BYTES-1:0] data,
    output logic                     ea_int,
    output logic                     busy,
    input  logic                     ld_we,
    input  logic [INT_ROM_WID-1:0]   ld_addr,
    input  logic [7:0]               ld_data,
    output logic                     ld_err
);

    localparam int unsigned DEPTH = 1 << INT_ROM_WID;

    typedef enum logic [1:0] {IDLE, READ, LAST, DONE} state_t;

    state_t                   state;
    logic [7:0]               mem [DEPTH];
    logic [7:0]               mem_q;
    logic                     zero_q;
    logic                     cap_v;
    logic [1:0]               cap_lane;
    logic [1:0]               k;
    logic [15:0]              base;
    logic [15:0]              rd_addr;
    logic                     rd_int;
    logic                     rd_en;
    logic                     wr_en;
    logic [8*FETCH_BYTES-1:0] assembly;

`ifdef OC8051_ROM_CACHE_EN
    logic [15:0]              tag;
    logic                     valid;
`endif

    assign ea_int  = ~|addr[15:INT_ROM_WID];
    assign busy    = (state != IDLE);
    assign rd_addr = base + 16'(k);
    assign rd_int  = ~|rd_addr[15:INT_ROM_WID];
    assign rd_en   = (state == READ) && rd_int;
    assign wr_en   = (state == IDLE) && ld_we && !rst;

    // Single-port array: writes only in IDLE, reads only in READ, so the two never collide.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[ld_addr] <= ld_data;
        if (rd_en)
            mem_q <= mem[rd_addr[INT_ROM_WID-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack      <= 1'b0;
            ld_err   <= 1'b0;
            data     <= '0;
            assembly <= '0;
            cap_v    <= 1'b0;
            cap_lane <= '0;
            zero_q   <= 1'b0;
            k        <= '0;
            base     <= '0;
`ifdef OC8051_ROM_CACHE_EN
            tag      <= '0;
            valid    <= 1'b0;
`endif
        end else begin
            ack    <= 1'b0;
            ld_err <= ld_we && (state != IDLE);
            cap_v  <= 1'b0;

            // Bytes land one cycle after their read; lanes assemble off to the side
            // so the visible data only changes together with ack.
            if (cap_v)
                assembly[{cap_lane, 3'b000} +: 8] <= zero_q ? 8'h00 : mem_q;

            unique case (state)
                IDLE: begin
                    if (ld_we) begin
`ifdef OC8051_ROM_CACHE_EN
                        valid <= 1'b0;
`endif
                    end else if (req) begin
`ifdef OC8051_ROM_CACHE_EN
                        if (valid && addr == tag) begin
                            state <= DONE;
                        end else begin
                            tag   <= addr;
                            base  <= addr;
                            k     <= '0;
                            state <= READ;
                        end
`else
                        base  <= addr;
                        k     <= '0;
                        state <= READ;
`endif
                    end
                end
                READ: begin
                    cap_v    <= 1'b1;
                    cap_lane <= k;
                    zero_q   <= !rd_int;
                    if (k == 2'(FETCH_BYTES - 1))
                        state <= LAST;
                    else
                        k <= k + 2'd1;
                end
                LAST: begin
                    state <= DONE;
                end
                DONE: begin
                    ack   <= 1'b1;
                    data  <= assembly;
                    state <= IDLE;
`ifdef OC8051_ROM_CACHE_EN
                    valid <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oc8051_prog_rom.sv
// Self-checking bench for oc8051_prog_rom (INT_ROM_WID=7, FETCH_BYTES=3); honours OC8051_ROM_CACHE_EN.
module tb_oc8051_prog_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [23:0] data;
    logic        ea_int;
    logic        busy;
    logic        ld_we;
    logic [6:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        ld_err;

    oc8051_prog_rom #(.INT_ROM_WID(7), .FETCH_BYTES(3)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .ack(ack), .data(data),
        .ea_int(ea_int), .busy(busy), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

`ifdef OC8051_ROM_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  model [128];
    logic [23:0] sbq [$];
    bit          c_valid = 1'b0;
    logic [15:0] c_tag = '0;

    typedef struct {
        logic [15:0] a;
        logic [23:0] d;
        logic        ea;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [6:0] a, input logic [7:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_we = 1'b0;
        model[a] = d;
        c_valid = 1'b0;
        chk("ld_err_idle", 32'(ld_err), 32'd0);
    endtask

    // mode 0: plain fetch, req dropped after accept
    // mode 1: ld_we while busy (to 0x00)
    // mode 2: ld_we (0x05=5A) together with req in IDLE
    // mode 3: req held past ack -> back-to-back refetch of the same address
    task automatic fetch(input logic [15:0] a, input logic [23:0] exp, input logic exp_ea,
                         input int mode, input string nm);
        int lat;
        bit got;
        if (mode == 2) begin
            ld_we = 1'b1; ld_addr = 7'h05; ld_data = 8'h5A;
        end
        req = 1'b1; addr = a;
        #1;
        chk({nm, "_ea"}, 32'(ea_int), 32'(exp_ea));
        sbq.push_back(exp);
        if (mode == 2) begin
            @(posedge clk); #1;
            ld_we = 1'b0;
            model[5] = 8'h5A;
            c_valid = 1'b0;
            chk({nm, "_not_accepted"}, 32'(busy), 32'd0);
        end
        lat = (CACHE && c_valid && c_tag == a) ? 1 : 5;
        @(posedge clk);
        c_tag = a; c_valid = 1'b1;
        got = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n == 1 && mode != 3) req = 1'b0;
            if (ack) begin
                got = 1'b1;
                chk({nm, "_latency"}, 32'(n), 32'(lat));
                chk({nm, "_data"}, 32'(data), 32'(sbq.pop_front()));
                break;
            end
            if (mode == 1) begin
                if (n == 1) begin
                    chk({nm, "_busy"}, 32'(busy), 32'd1);
                    ld_we = 1'b1; ld_addr = 7'h00; ld_data = 8'hEE;
                end else if (n == 2) begin
                    ld_we = 1'b0;
                    chk({nm, "_ld_err_pulse"}, 32'(ld_err), 32'd1);
                end else if (n == 3) begin
                    chk({nm, "_ld_err_clear"}, 32'(ld_err), 32'd0);
                end
            end
        end
        chk({nm, "_ack_seen"}, 32'(got), 32'd1);
        if (mode == 3) begin
            @(posedge clk); #1;
            chk({nm, "_b2b_accept"}, 32'(busy), 32'd1);
            req = 1'b0;
            sbq.push_back(exp);
            got = 1'b0;
            for (int n = 2; n <= 12; n++) begin
                @(posedge clk); #1;
                if (ack) begin
                    got = 1'b1;
                    chk({nm, "_b2b_data"}, 32'(data), 32'(sbq.pop_front()));
                    break;
                end
            end
            chk({nm, "_b2b_ack_seen"}, 32'(got), 32'd1);
        end
        @(posedge clk); #1;
        chk({nm, "_ack_pulse"}, 32'(ack), 32'd0);
    endtask

    initial begin
        int acks;
        vt[0] = '{16'h0000, 24'h250002, 1'b1};
        vt[1] = '{16'h007F, 24'h000022, 1'b1};
        vt[2] = '{16'h0080, 24'h000000, 1'b0};
        vt[3] = '{16'hFFFF, 24'h000200, 1'b0};
        vt[4] = '{16'h007E, 24'h002211, 1'b1};
        vt[5] = '{16'h0002, 24'h017425, 1'b1};
        vt[6] = '{16'h1234, 24'h000000, 1'b0};

        rst = 1'b1; req = 1'b0; addr = '0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ld_err", 32'(ld_err), 32'd0);
        chk("rst_data", 32'(data), 32'd0);

        load(7'h00, 8'h02);
        load(7'h01, 8'h00);
        load(7'h02, 8'h25);
        load(7'h03, 8'h74);
        load(7'h04, 8'h01);
        load(7'h06, 8'h33);
        load(7'h7E, 8'h11);
        load(7'h7F, 8'h22);

        for (int i = 0; i < 7; i++)
            fetch(vt[i].a, vt[i].d, vt[i].ea, 0, $sformatf("vec%0d", i));

        fetch(16'h0000, 24'h250002, 1'b1, 1, "busy_ld");
        fetch(16'hFFFF, 24'h000200, 1'b0, 0, "reread");
        fetch(16'h0004, 24'h335A01, 1'b1, 2, "ld_req");
        fetch(16'h0004, 24'h335A01, 1'b1, 3, "b2b");

        // Reset while in READ abandons the fetch.
        req = 1'b1; addr = 16'h0002;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        c_valid = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        acks = 0;
        repeat (8) begin
            @(posedge clk); #1;
            acks += int'(ack);
        end
        chk("midrst_no_ack", 32'(acks), 32'd0);
        fetch(16'h0002, 24'h017425, 1'b1, 0, "post_rst");

        fetch(16'h0000, 24'h250002, 1'b1, 0, "rep1");
        fetch(16'h0000, 24'h250002, 1'b1, 0, "rep2");
        load(7'h01, 8'hAA);
        fetch(16'h0000, 24'h25AA02, 1'b1, 0, "after_ld");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
